// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI mode-0 master that shifts out one MSB-first frame of up to MAX_BITS bits per i_start.
//   i_clk, i_reset_n (async, active-low)  clock and reset
//   i_start, i_data, i_len                frame request, payload, length in bits (captured at start)
//   o_busy, o_done                        frame in progress, one-cycle completion pulse
//   o_csb, o_sclk, o_mosi                 registered SPI link (csb active-low, sclk idles low)
module spi_frame_tx #(
  parameter int MAX_BITS = 32,
  parameter int LEN_W    = 6,
  parameter int HALF_DIV = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_start,
  input  logic [MAX_BITS-1:0] i_data,
  input  logic [LEN_W-1:0]    i_len,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_csb,
  output logic                o_sclk,
  output logic                o_mosi
);
  localparam int PW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;
  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [LEN_W-1:0]    bits_q, bits_d, len_c;
  logic [MAX_BITS-1:0] shift_q, shift_d, load_c;
  logic                busy_q, busy_d, done_q, done_d, csb_q, csb_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, last_c;
  always_comb begin
    len_c   = (i_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : i_len;
    // left-justify so bit len-1 lands on the shift MSB
    load_c  = i_data << (LEN_W'(MAX_BITS) - len_c);
    last_c  = phase_q == PW'(HALF_DIV - 1);
    state_d = state_q;
    phase_d = (state_q == IDLE || last_c) ? '0 : phase_q + 1'b1;
    bits_d  = bits_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    csb_d   = csb_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: if (i_start && len_c != '0) begin
        state_d = LOW;
        shift_d = load_c;
        bits_d  = len_c - 1'b1;
        busy_d  = 1'b1;
        csb_d   = 1'b0;
        mosi_d  = load_c[MAX_BITS-1];
      end
      LOW: if (last_c) begin
        state_d = HIGH;
        sclk_d  = 1'b1;
      end
      HIGH: if (last_c) begin
        sclk_d = 1'b0;
        if (bits_q != '0) begin
          state_d = LOW;
          shift_d = shift_q << 1;
          bits_d  = bits_q - 1'b1;
          mosi_d  = shift_d[MAX_BITS-1];
        end else begin
          state_d = HOLD;
          mosi_d  = 1'b0;
        end
      end
      HOLD: if (last_c) begin
        state_d = GAP;
        csb_d   = 1'b1;
      end
      GAP: if (last_c) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      bits_q  <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      csb_q   <= csb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_csb  = csb_q;
  assign o_sclk = sclk_q;
  assign o_mosi = mosi_q;
endmodule
